// File: rtl/cfu_wb_pkg.sv
// cfu_wb_pkg: shared Wishbone widths and the scratch RAM FSM state type
package cfu_wb_pkg;
  localparam int WB_ADR_W = 30;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  localparam int LATENCY_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} scratch_state_t;
endpackage

// File: rtl/cfu_ram_bank.sv
// cfu_ram_bank: single-port RAM of 4 byte lanes with registered read port
// clk_i, rst_ni: clock and async active-low reset (read register only)
// addr_i: word address; re_i: load read register; we_i: per-lane write enables
// wdata_i: write data; rdata_o: registered read data, holds until next re_i
module cfu_ram_bank
  import cfu_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [AW-1:0]       addr_i,
  input  logic                re_i,
  input  logic [WB_SEL_W-1:0] we_i,
  input  logic [WB_DAT_W-1:0] wdata_i,
  output logic [WB_DAT_W-1:0] rdata_o
);
  for (genvar l = 0; l < WB_SEL_W; l++) begin : g_lane
    logic [7:0] lane_q [DEPTH];
    logic [7:0] rd_q;
    always_ff @(posedge clk_i)
      if (we_i[l]) lane_q[addr_i] <= wdata_i[8*l+:8];
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) rd_q <= '0;
      else if (re_i) rd_q <= lane_q[addr_i];
    assign rdata_o[8*l+:8] = rd_q;
  end
endmodule

// File: rtl/cfu_wb_scratch_ram.sv
// cfu_wb_scratch_ram: Wishbone classic byte-writable scratchpad with programmable wait states
// clk, reset_n: clock and async active-low reset
// wb_adr/wb_dat_mosi/wb_sel/wb_cyc/wb_stb/wb_we: request; wb_cti/wb_bte ignored
// wb_dat_miso/wb_ack/wb_err: response
// CFU_SCRATCH_RAM_RANGE_CHECK_EN: when defined, offsets >= DEPTH terminate with wb_err;
// otherwise offsets alias modulo DEPTH and wb_err stays 0
module cfu_wb_scratch_ram
  import cfu_wb_pkg::*;
#(
  parameter int unsigned          DEPTH     = 1024,
  parameter logic [WB_ADR_W-1:0]  BASE_WORD = '0,
  parameter int unsigned          LATENCY   = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WB_ADR_W-1:0] wb_adr,
  input  logic [WB_DAT_W-1:0] wb_dat_mosi,
  input  logic [WB_SEL_W-1:0] wb_sel,
  input  logic                wb_cyc,
  input  logic                wb_stb,
  input  logic                wb_we,
  input  logic [2:0]          wb_cti,
  input  logic [1:0]          wb_bte,
  output logic [WB_DAT_W-1:0] wb_dat_miso,
  output logic                wb_ack,
  output logic                wb_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LATENCY_W-1:0] LAT = LATENCY_W'(LATENCY);
  scratch_state_t        state_q;
  logic [LATENCY_W-1:0]  cnt_q;
  logic                  we_q, ok_q, ack_q, err_q;
  logic [WB_SEL_W-1:0]   sel_q, wen_w;
  logic [WB_DAT_W-1:0]   dat_q;
  logic [AW-1:0]         off_q, addr_w;
  logic [WB_ADR_W-1:0]   off_w;
  logic                  ok_w, req_w, rd_w;
  assign off_w = wb_adr - BASE_WORD;
`ifdef CFU_SCRATCH_RAM_RANGE_CHECK_EN
  assign ok_w = off_w < WB_ADR_W'(DEPTH);
`else
  assign ok_w = 1'b1;
`endif
  assign req_w = wb_cyc & wb_stb;
  // read is issued one cycle before RESP so the bank's registered output lines up with ack;
  // with zero wait states that cycle is the IDLE sample itself, using the live address
  assign rd_w = state_q == IDLE ? LATENCY == 0 && req_w && !wb_we && ok_w
                                : state_q == WAIT && cnt_q == LATENCY_W'(1) && wb_cyc && !we_q && ok_q;
  assign addr_w = state_q == IDLE ? off_w[AW-1:0] : off_q;
  assign wen_w = (state_q == RESP && we_q && ok_q) ? sel_q : '0;
  assign wb_ack = ack_q;
  assign wb_err = err_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ok_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      off_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (req_w) begin
          we_q  <= wb_we;
          sel_q <= wb_sel;
          dat_q <= wb_dat_mosi;
          off_q <= off_w[AW-1:0];
          ok_q  <= ok_w;
          cnt_q <= LAT;
          if (LATENCY == 0) begin
            state_q <= RESP;
            ack_q   <= ok_w;
            err_q   <= !ok_w;
          end else state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (!wb_cyc) state_q <= IDLE;
          else if (cnt_q == LATENCY_W'(1)) begin
            state_q <= RESP;
            ack_q   <= ok_q;
            err_q   <= !ok_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  cfu_ram_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .addr_i  (addr_w),
    .re_i    (rd_w),
    .we_i    (wen_w),
    .wdata_i (dat_q),
    .rdata_o (wb_dat_miso)
  );
endmodule
